// File: rtl/dm_access_unit_pkg.sv
// rtl/dm_access_unit_pkg.sv - shared encodings and helpers for the data-memory access unit
package dm_access_unit_pkg;

  localparam logic [3:0] MASK_BYTE = 4'b0001;
  localparam logic [3:0] MASK_HALF = 4'b0011;
  localparam logic [3:0] MASK_WORD = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmState;

  // Word-index width; never below one bit so a single-word RAM still elaborates.
  function automatic int idxWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/dm_access_unit_if.sv
// rtl/dm_access_unit_if.sv - request/response bus between EX/MEM and the access unit
interface dm_access_unit_if;

  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_mask;
  logic        req_ready;
  logic        stall;
  logic        rsp_valid;
  logic [31:0] MemRData;
  logic [1:0]  subAddr;
  logic        addr_err;
  logic [31:0] err_addr;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mask,
    input  req_ready, stall, rsp_valid, MemRData, subAddr, addr_err, err_addr
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mask,
    output req_ready, stall, rsp_valid, MemRData, subAddr, addr_err, err_addr
  );

endinterface

// File: rtl/dm_ram.sv
// rtl/dm_ram.sv - single-port word RAM with byte write enables and registered read
module dm_ram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int IDX_W       = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             we,
  input  logic [3:0]       be,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Byte-lane writes; a reset on the access edge suppresses the write entirely.
  always_ff @(posedge clk) begin
    if (!reset && en && we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  // Read register only updates on loads so the last loaded word is held.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata <= '0;
    end else if (en && !we) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dm_access_unit.sv
// rtl/dm_access_unit.sv - checks, aligns and sequences load/store accesses to the data RAM
module dm_access_unit
  import dm_access_unit_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic            clk,
  input logic            reset,
  dm_access_unit_if.slave bus
);

  localparam int IDX_W = idxWidth(DEPTH_WORDS);
  localparam logic [2:0] WAIT_INIT = (WAIT_CYCLES > 0) ? 3'(WAIT_CYCLES - 1) : 3'd0;

  dmState state, nextState;
  logic [2:0]       waitCnt;
  logic             latWe;
  logic [IDX_W-1:0] latIdx;
  logic [3:0]       latBe;
  logic [31:0]      latWd;
  logic [1:0]       latSub;
  logic             reqLegal;
  logic             accept;

  // Request legality: known size, natural alignment and in-range word index.
  always_comb begin
    reqLegal = 1'b0;
    case (bus.req_mask)
      MASK_BYTE: reqLegal = 1'b1;
      MASK_HALF: reqLegal = !bus.req_addr[0];
      MASK_WORD: reqLegal = (bus.req_addr[1:0] == 2'b00);
      default:   reqLegal = 1'b0;
    endcase
    if ({2'b00, bus.req_addr[31:2]} >= 32'(DEPTH_WORDS)) reqLegal = 1'b0;
  end

  assign accept = (state == ST_IDLE) && bus.req_valid;

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= nextState;
  end

  // Next-state and handshake outputs.
  always_comb begin
    nextState     = state;
    bus.req_ready = 1'b0;
    bus.stall     = 1'b0;
    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (accept && reqLegal) nextState = (WAIT_CYCLES > 0) ? ST_WAIT : ST_RESP;
      end
      ST_WAIT: begin
        bus.stall = 1'b1;
        if (waitCnt == 3'd0) nextState = ST_RESP;
      end
      ST_RESP: begin
        bus.stall = 1'b1;
        nextState = ST_IDLE;
      end
      default: nextState = ST_IDLE;
    endcase
  end

  // Request latching, wait counter and registered response/error pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      waitCnt       <= '0;
      latWe         <= 1'b0;
      latIdx        <= '0;
      latBe         <= '0;
      latWd         <= '0;
      latSub        <= '0;
      bus.rsp_valid <= 1'b0;
      bus.subAddr   <= '0;
      bus.addr_err  <= 1'b0;
      bus.err_addr  <= '0;
    end else begin
      bus.rsp_valid <= (state == ST_RESP);
      bus.addr_err  <= accept && !reqLegal;
      if (accept && !reqLegal) bus.err_addr <= bus.req_addr;
      if (accept && reqLegal) begin
        latWe   <= bus.req_we;
        latIdx  <= bus.req_addr[IDX_W+1:2];
        latBe   <= bus.req_mask << bus.req_addr[1:0];
        latWd   <= bus.req_wdata << {bus.req_addr[1:0], 3'b000};
        latSub  <= bus.req_addr[1:0];
        waitCnt <= WAIT_INIT;
      end else if (state == ST_WAIT && waitCnt != 3'd0) begin
        waitCnt <= waitCnt - 3'd1;
      end
      if (state == ST_RESP) bus.subAddr <= latSub;
    end
  end

  dm_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) uRam (
    .clk  (clk),
    .reset(reset),
    .en   (state == ST_RESP),
    .we   (latWe),
    .be   (latBe),
    .addr (latIdx),
    .wdata(latWd),
    .rdata(bus.MemRData)
  );

endmodule

// File: tb/tb_dm_access_unit.sv
// tb/tb_dm_access_unit.sv - scoreboard bench for dm_access_unit at three wait-state settings
module tb_dm_access_unit;

  typedef struct {
    bit          isErr;
    bit          isLoad;
    logic [31:0] data;
    logic [1:0]  sub;
    logic [31:0] eaddr;
    int          lat;
  } expT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstS     [3];
  logic        reqValid [3];
  logic        reqWe    [3];
  logic [31:0] reqAddr  [3];
  logic [31:0] reqWdata [3];
  logic [3:0]  reqMask  [3];
  logic        readyO   [3];
  logic        stallO   [3];
  logic        rspO     [3];
  logic        errO     [3];
  logic [31:0] rdataO   [3];
  logic [1:0]  subO     [3];
  logic [31:0] errAddrO [3];

  logic [31:0] lastRd [3];
  expT expQ[$];
  int checks = 0;
  int failures = 0;

  for (genvar g = 0; g < 3; g++) begin : gDut
    dm_access_unit_if bus();
    assign bus.req_valid = reqValid[g];
    assign bus.req_we    = reqWe[g];
    assign bus.req_addr  = reqAddr[g];
    assign bus.req_wdata = reqWdata[g];
    assign bus.req_mask  = reqMask[g];
    assign readyO[g]     = bus.req_ready;
    assign stallO[g]     = bus.stall;
    assign rspO[g]       = bus.rsp_valid;
    assign errO[g]       = bus.addr_err;
    assign rdataO[g]     = bus.MemRData;
    assign subO[g]       = bus.subAddr;
    assign errAddrO[g]   = bus.err_addr;
    dm_access_unit #(
      .DEPTH_WORDS(1024),
      .WAIT_CYCLES((g == 0) ? 1 : ((g == 1) ? 3 : 0))
    ) dut (
      .clk  (clk),
      .reset(rstS[g]),
      .bus  (bus)
    );
  end

  function automatic int waitOf(input int d);
    case (d)
      0: return 1;
      1: return 3;
      default: return 0;
    endcase
  endfunction

  task automatic doAccess(input int d, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask,
                          input bit expErr, input logic [31:0] expData,
                          input logic [1:0] expSub, input string name);
    expT e;
    int  lat;
    int  stalls;
    bit  got;
    @(negedge clk);
    checks++;
    if (readyO[d] !== 1'b1) begin
      failures++;
      $display("FAIL %s ready: got %b want 1", name, readyO[d]);
    end
    reqValid[d] = 1'b1; reqWe[d] = we; reqAddr[d] = addr; reqWdata[d] = wdata; reqMask[d] = mask;
    e.isErr  = expErr;
    e.isLoad = !we;
    e.data   = we ? lastRd[d] : expData;
    e.sub    = expSub;
    e.eaddr  = addr;
    e.lat    = expErr ? 1 : waitOf(d) + 2;
    expQ.push_back(e);
    @(posedge clk); #1;
    reqValid[d] = 1'b0;
    lat = 0; stalls = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (stallO[d] === 1'b1) stalls++;
      if (rspO[d] === 1'b1 || errO[d] === 1'b1) got = 1;
    end
    e = expQ.pop_front();
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL %s timeout: no rsp_valid/addr_err within 20 cycles", name);
    end else begin
      checks++;
      if (errO[d] !== e.isErr || rspO[d] !== !e.isErr) begin
        failures++;
        $display("FAIL %s kind: got rsp=%b err=%b want err=%b", name, rspO[d], errO[d], e.isErr);
      end
      checks++;
      if (lat != e.lat) begin
        failures++;
        $display("FAIL %s latency: got %0d want %0d", name, lat, e.lat);
      end
      checks++;
      if (stalls != (e.isErr ? 0 : waitOf(d) + 1)) begin
        failures++;
        $display("FAIL %s stall cycles: got %0d want %0d", name, stalls, e.isErr ? 0 : waitOf(d) + 1);
      end
      if (e.isErr) begin
        checks++;
        if (errAddrO[d] !== e.eaddr) begin
          failures++;
          $display("FAIL %s err_addr: got %h want %h", name, errAddrO[d], e.eaddr);
        end
      end else begin
        checks++;
        if (rdataO[d] !== e.data) begin
          failures++;
          $display("FAIL %s MemRData: got %h want %h", name, rdataO[d], e.data);
        end
        checks++;
        if (subO[d] !== e.sub) begin
          failures++;
          $display("FAIL %s subAddr: got %0d want %0d", name, subO[d], e.sub);
        end
      end
      @(negedge clk);
      checks++;
      if (rspO[d] !== 1'b0 || errO[d] !== 1'b0) begin
        failures++;
        $display("FAIL %s pulse width: got rsp=%b err=%b want 0 0", name, rspO[d], errO[d]);
      end
    end
    if (!expErr && !we) lastRd[d] = expData;
  endtask

  task automatic test_reset();
    for (int d = 0; d < 3; d++) begin
      checks++;
      if (readyO[d] !== 1'b1 || stallO[d] !== 1'b0 || rspO[d] !== 1'b0 || errO[d] !== 1'b0) begin
        failures++;
        $display("FAIL reset_ctl dut%0d: got ready=%b stall=%b rsp=%b err=%b want 1 0 0 0",
                 d, readyO[d], stallO[d], rspO[d], errO[d]);
      end
      checks++;
      if (rdataO[d] !== 32'h0 || subO[d] !== 2'd0 || errAddrO[d] !== 32'h0) begin
        failures++;
        $display("FAIL reset_data dut%0d: got rdata=%h sub=%0d err_addr=%h want 0", d, rdataO[d], subO[d], errAddrO[d]);
      end
    end
  endtask

  task automatic test_word_store_load();
    doAccess(0, 1, 32'h10, 32'hDEADBEEF, 4'b1111, 0, 32'h0, 2'd0, "t1_store");
    doAccess(0, 0, 32'h10, 32'h0, 4'b1111, 0, 32'hDEADBEEF, 2'd0, "t1_load");
  endtask

  task automatic test_byte_lanes();
    doAccess(0, 1, 32'h20, 32'h00000000, 4'b1111, 0, 32'h0, 2'd0, "t2_clear");
    doAccess(0, 1, 32'h23, 32'h000000AB, 4'b0001, 0, 32'h0, 2'd3, "t2_store_byte");
    doAccess(0, 0, 32'h20, 32'h0, 4'b1111, 0, 32'hAB000000, 2'd0, "t2_load_byte");
    doAccess(0, 1, 32'h22, 32'h00001234, 4'b0011, 0, 32'h0, 2'd2, "t2_store_half");
    doAccess(0, 0, 32'h22, 32'h0, 4'b0011, 0, 32'h12340000, 2'd2, "t2_load_half");
  endtask

  task automatic test_misalign();
    doAccess(0, 0, 32'h11, 32'h0, 4'b0011, 1, 32'h0, 2'd0, "t3_half_odd");
    doAccess(0, 1, 32'h12, 32'h01020304, 4'b1111, 1, 32'h0, 2'd0, "t3_word_mis");
    doAccess(0, 0, 32'h10, 32'h0, 4'b1111, 0, 32'hDEADBEEF, 2'd0, "t3_unchanged");
    doAccess(0, 0, 32'h20, 32'h0, 4'b0101, 1, 32'h0, 2'd0, "t3_bad_mask");
  endtask

  task automatic test_range();
    doAccess(0, 0, 32'h1000, 32'h0, 4'b1111, 1, 32'h0, 2'd0, "t4_oob");
    doAccess(0, 1, 32'hFFC, 32'hCAFEF00D, 4'b1111, 0, 32'h0, 2'd0, "t4_store_last");
    doAccess(0, 0, 32'hFFC, 32'h0, 4'b1111, 0, 32'hCAFEF00D, 2'd0, "t4_load_last");
  endtask

  task automatic test_reset_abort();
    int seen;
    doAccess(1, 1, 32'h40, 32'h11111111, 4'b1111, 0, 32'h0, 2'd0, "t5_old");
    @(negedge clk);
    reqValid[1] = 1'b1; reqWe[1] = 1'b1; reqAddr[1] = 32'h40; reqWdata[1] = 32'h55555555; reqMask[1] = 4'b1111;
    @(posedge clk); #1;
    reqValid[1] = 1'b0;
    @(posedge clk); #1;
    rstS[1] = 1'b1;
    @(posedge clk); #1;
    rstS[1] = 1'b0;
    lastRd[1] = 32'h0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (rspO[1] === 1'b1 || errO[1] === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      failures++;
      $display("FAIL t5_no_rsp: got %0d response cycles want 0", seen);
    end
    checks++;
    if (readyO[1] !== 1'b1 || stallO[1] !== 1'b0) begin
      failures++;
      $display("FAIL t5_idle: got ready=%b stall=%b want 1 0", readyO[1], stallO[1]);
    end
    doAccess(1, 0, 32'h40, 32'h0, 4'b1111, 0, 32'h11111111, 2'd0, "t5_load_old");
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    expT e;
    int idx;
    int nRsp;
    int lastAt;
    bit acc;
    vals[0] = 32'hA0A0A0A0; vals[1] = 32'hB1B1B1B1; vals[2] = 32'hC2C2C2C2;
    for (int k = 0; k < 3; k++)
      doAccess(2, 1, 32'(k * 4), vals[k], 4'b1111, 0, 32'h0, 2'd0, "t6_fill");
    idx = 0; nRsp = 0; lastAt = -1;
    @(negedge clk);
    reqValid[2] = 1'b1; reqWe[2] = 1'b0; reqAddr[2] = 32'h0; reqWdata[2] = 32'h0; reqMask[2] = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      if (c > 0) @(negedge clk);
      if (rspO[2] === 1'b1) begin
        checks++;
        if (expQ.size() == 0) begin
          failures++;
          $display("FAIL t6_dup: got extra rsp_valid at cycle %0d want none", c);
        end else begin
          e = expQ.pop_front();
          checks++;
          if (rdataO[2] !== e.data) begin
            failures++;
            $display("FAIL t6_data: got %h want %h", rdataO[2], e.data);
          end
        end
        if (lastAt >= 0) begin
          checks++;
          if (c - lastAt != 2) begin
            failures++;
            $display("FAIL t6_gap: got %0d want 2", c - lastAt);
          end
        end
        lastAt = c;
        nRsp++;
      end
      acc = (readyO[2] === 1'b1) && reqValid[2];
      if (acc) begin
        e.isErr = 0; e.isLoad = 1; e.data = vals[idx]; e.sub = 2'd0; e.eaddr = reqAddr[2]; e.lat = 2;
        expQ.push_back(e);
      end
      @(posedge clk); #1;
      if (acc) begin
        idx++;
        if (idx == 3) reqValid[2] = 1'b0;
        else reqAddr[2] = 32'(idx * 4);
      end
    end
    checks++;
    if (nRsp != 3 || expQ.size() != 0) begin
      failures++;
      $display("FAIL t6_count: got %0d responses, %0d pending want 3, 0", nRsp, expQ.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 3; d++) begin
      rstS[d] = 1'b1; reqValid[d] = 1'b0; reqWe[d] = 1'b0;
      reqAddr[d] = '0; reqWdata[d] = '0; reqMask[d] = '0; lastRd[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) rstS[d] = 1'b0;
    @(negedge clk);
    test_reset();
    test_word_store_load();
    test_byte_lanes();
    test_misalign();
    test_range();
    test_reset_abort();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dm_access_unit.md
Name: dm_access_unit

Overview:
Data-memory access stage. Sits directly upstream of the load-extension stage and feeds it.
- Accepts load/store requests from the EX/MEM boundary.
- Aligns store data and byte enables, then performs the access on an internal word-organised RAM with configurable wait states.
- Returns the raw read word plus the byte offset, so downstream logic can select and extend the loaded data.
- Detects misaligned, illegal-mask and out-of-range accesses.

Parameters:
DEPTH_WORDS, 1024, number of 32-bit words in the RAM; the word index is addr[11:2] at the default depth.
WAIT_CYCLES, 1, extra memory latency in cycles; legal range 0..7.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  synchronous, active-high reset.
req_valid  in  1  request present; sampled only while req_ready=1.
req_we  in  1  1=store, 0=load.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-justified (byte in [7:0], half in [15:0]).
req_mask  in  4  access size in low lanes: 4'b0001 byte, 4'b0011 half, 4'b1111 word.
req_ready  out  1  unit idle and able to accept a request.
stall  out  1  accepted access still in progress; freezes the pipeline.
rsp_valid  out  1  one-cycle pulse: load data available, or store committed.
MemRData  out  32  raw word read from RAM, unshifted.
subAddr  out  2  req_addr[1:0] of the completed access.
addr_err  out  1  one-cycle pulse: request rejected.
err_addr  out  32  address of the last rejected request.

Behaviour:
- Reset values: all outputs 0 except req_ready=1; FSM goes to IDLE.
- RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, run the checks. A request is illegal if:
    - mask is not one of {0001, 0011, 1111};
    - it is a half access with addr[0]=1;
    - it is a word access with addr[1:0]!=0;
    - the word index is >= DEPTH_WORDS.
  - Illegal request: next cycle addr_err=1 for one cycle, err_addr=req_addr, no RAM access, stay in IDLE.
  - Legal request: latch we, word index, be = mask << addr[1:0], and wd = wdata << (8*addr[1:0]), with all shifts truncated to 4 and 32 bits. Go to WAIT if WAIT_CYCLES>0, else RESP.
- WAIT:
  - A counter loads WAIT_CYCLES-1 on entry and decrements each cycle; at 0, go to RESP.
  - stall=1, req_ready=0.
- RESP:
  - Store: write only the bytes with be set at this clock edge.
  - Load: MemRData is captured from RAM.
  - Next cycle: rsp_valid=1, subAddr=latched addr[1:0], back to IDLE.
  - stall=1 while in RESP; stall=0 in the rsp_valid cycle.
- Latency: request accepted at edge N; rsp_valid is high in the cycle after edge N+1+WAIT_CYCLES.
- MemRData and subAddr hold their values until the next load response. A store response leaves MemRData unchanged and updates subAddr.
- Requests arriving while req_ready=0 are ignored; the upstream must hold them.
- Back-to-back: a request may be accepted in the same cycle rsp_valid=1, because the FSM is already in IDLE.
- Store followed by load to the same word returns the updated data; there is no bypass, because the write commits before the load is accepted.
- Reset in WAIT or RESP aborts the access: no write is committed, and no rsp_valid or addr_err is produced.
- Single-port RAM: one access at a time, so there are no read/write conflicts.

Decomposition:
- Shared package:
  - mask encodings MASK_BYTE=4'b0001, MASK_HALF=4'b0011, MASK_WORD=4'b1111;
  - FSM state encodings;
  - clog2-based word-index width.
- One natural sub-module, dm_ram: synchronous single-port RAM with 4 byte-write enables and a registered read, DEPTH_WORDS words.
- Alignment, checking and FSM stay in the top level.

Test Plan:
1. Word store, then load, WAIT_CYCLES=1: store addr 0x10 data 0xDEADBEEF; load 0x10 -> MemRData=0xDEADBEEF, subAddr=0, rsp_valid exactly 3 cycles after acceptance, stall high for 2 cycles.
2. Byte lanes: word 0x20 = 0x00000000; store byte 0xAB at 0x23; load word 0x20 -> 0xAB000000. Store half 0x1234 at 0x22; load -> 0x12340000, subAddr=2 on a half load from 0x22.
3. Misalignment: half load at 0x11 -> addr_err pulse, err_addr=0x11, no rsp_valid. Word store at 0x12 -> addr_err, RAM word 0x10 unchanged. Mask 4'b0101 -> addr_err.
4. Out of range, DEPTH_WORDS=1024: load 0x1000 -> addr_err, err_addr=0x1000. Load 0x0FFC -> normal response.
5. Reset mid-operation: WAIT_CYCLES=3, store 0x55555555 to 0x40; assert reset in the second WAIT cycle -> no rsp_valid, req_ready=1 after reset. Load 0x40 -> old value.
6. Back-to-back, WAIT_CYCLES=0: hold req_valid with loads to 0x0, 0x4, 0x8 -> one rsp_valid every 2 cycles, data in order, no lost or duplicated responses.
